dkong_vram_bridge: RTL

DKONG_VRAM_BRIDGE -- requirements
Module: dkong_vram_bridge

---
 rtl/dkong_vram_bridge_pkg.sv | 16 +
 rtl/dkong_vram_wbuf.sv | 39 +++
 rtl/dkong_vram_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dkong_vram_bridge_pkg.sv
// Shared definitions for the Donkey Kong CPU-to-VRAM bridge: FSM encoding and parameter defaults.
package dkong_vram_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrStb,
        StRdWait,
        StRdStb,
        StRdCapt,
        StRdHold
    } bridge_state_e;

    localparam logic [5:0] VRAM_BASE_DEF   = 6'h1D;
    localparam logic [7:0] RD_HOLD_MAX_DEF = 8'd255;

endpackage

// File: rtl/dkong_vram_wbuf.sv
// One-entry posted write buffer; a push in the same tick as a pop reloads the entry.
module dkong_vram_wbuf (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [9:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_full,
    output logic [9:0] o_addr,
    output logic [7:0] o_data
);

    logic       r_full;
    logic [9:0] r_addr;
    logic [7:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_addr <= 10'h000;
            r_data <= 8'h00;
        end else if (i_en) begin
            if (i_push) begin
                r_full <= 1'b1;
                r_addr <= i_addr;
                r_data <= i_data;
            end else if (i_pop) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/dkong_vram_bridge.sv
// Arbitrates Z80 accesses to the tile VRAM window against the video fetch, posting writes
// and stalling reads until the RAM returns data.
module dkong_vram_bridge
    import dkong_vram_bridge_pkg::*;
#(
    parameter logic [5:0] VRAM_BASE   = VRAM_BASE_DEF,
    parameter logic [7:0] RD_HOLD_MAX = RD_HOLD_MAX_DEF
) (
    input  logic        CLK_24M,
    input  logic        I_RESETn,
    input  logic        CLK_EN,
    input  logic [15:0] I_CPU_AB,
    input  logic [7:0]  I_CPU_DB,
    input  logic        I_CPU_MREQn,
    input  logic        I_CPU_RDn,
    input  logic        I_CPU_WRn,
    output logic [7:0]  O_CPU_DB,
    output logic        O_CPU_WAITn,
    output logic [9:0]  O_VRAM_AB,
    output logic [7:0]  O_VRAM_DB,
    output logic        O_VRAM_WRn,
    output logic        O_VRAM_RDn,
    input  logic [7:0]  I_VRAM_DB,
    input  logic        I_VRAMBUSYn
);

    bridge_state_e r_state, w_state_next;

    logic       r_rd_prev, r_wr_prev;
    logic       r_rd_req, r_wr_wait;
    logic [7:0] r_cnt;
    logic [9:0] r_rd_addr;
    logic [7:0] r_rd_data;

    logic       w_dec, w_wr_fall, w_rd_fall;
    logic       w_wr_stb, w_rd_stb, w_rd_hold;
    logic       w_buf_full, w_can_push, w_push, w_pop;
    logic       w_wr_stall, w_rd_stall, w_cnt_max;
    logic [9:0] w_buf_addr;
    logic [7:0] w_buf_data;

    // Prev values reset low so a strobe already held low across reset is not taken as a new one
    assign w_dec     = ~I_CPU_MREQn & (I_CPU_AB[15:10] == VRAM_BASE);
    assign w_wr_fall = w_dec & r_wr_prev & ~I_CPU_WRn;
    assign w_rd_fall = w_dec & r_rd_prev & ~I_CPU_RDn & ~w_wr_fall;

    assign w_wr_stb  = (r_state == StWrStb);
    assign w_rd_stb  = (r_state == StRdStb);
    assign w_rd_hold = (r_state == StRdHold);
    assign w_cnt_max = (r_cnt == RD_HOLD_MAX);

    // The slot frees during the strobe tick, so a stalled write can land on that same edge
    assign w_can_push = ~w_buf_full | w_wr_stb;
    assign w_push     = CLK_EN & w_can_push & (w_wr_fall | r_wr_wait);
    assign w_pop      = CLK_EN & w_wr_stb;
    assign w_wr_stall = (w_wr_fall | r_wr_wait) & ~w_can_push;
    assign w_rd_stall = w_rd_fall | r_rd_req |
                        (r_state == StRdWait) | w_rd_stb | (r_state == StRdCapt);

    dkong_vram_wbuf u_wbuf (
        .i_clk   (CLK_24M),
        .i_rst_n (I_RESETn),
        .i_en    (CLK_EN),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_addr  (I_CPU_AB[9:0]),
        .i_data  (I_CPU_DB),
        .o_full  (w_buf_full),
        .o_addr  (w_buf_addr),
        .o_data  (w_buf_data)
    );

    always_ff @(posedge CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_state <= StIdle;
        end else if (CLK_EN) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_rd_prev <= 1'b0;
            r_wr_prev <= 1'b0;
            r_rd_req  <= 1'b0;
            r_wr_wait <= 1'b0;
            r_cnt     <= 8'd0;
            r_rd_addr <= 10'h000;
            r_rd_data <= 8'h00;
        end else if (CLK_EN) begin
            r_rd_prev <= I_CPU_RDn;
            r_wr_prev <= I_CPU_WRn;
            if (w_push) begin
                r_wr_wait <= 1'b0;
            end else if (w_wr_fall) begin
                r_wr_wait <= 1'b1;
            end
            // Held through any write drain so the FSM returns to the read afterwards
            if (w_rd_fall) begin
                r_rd_req  <= 1'b1;
                r_rd_addr <= I_CPU_AB[9:0];
            end else if (w_rd_stb) begin
                r_rd_req  <= 1'b0;
            end
            if (r_state != StRdWait) begin
                r_cnt <= 8'd0;
            end else if (!w_cnt_max) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == StRdCapt) begin
                r_rd_data <= I_VRAM_DB;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_rd_fall || r_rd_req) begin
                    w_state_next = StRdWait;
                end else if (w_buf_full && I_VRAMBUSYn) begin
                    w_state_next = StWrStb;
                end
            end
            StWrStb:  w_state_next = r_rd_req ? StRdWait : StIdle;
            StRdWait: begin
                // A pending write always goes first so the read sees it
                if (I_VRAMBUSYn || w_cnt_max) begin
                    w_state_next = w_buf_full ? StWrStb : StRdStb;
                end
            end
            StRdStb:  w_state_next = StRdCapt;
            StRdCapt: w_state_next = StRdHold;
            StRdHold: begin
                if (I_CPU_RDn) begin
                    w_state_next = StIdle;
                end
            end
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        O_VRAM_WRn  = ~w_wr_stb;
        O_VRAM_RDn  = ~w_rd_stb;
        O_VRAM_AB   = 10'h000;
        O_VRAM_DB   = 8'h00;
        O_CPU_DB    = 8'h00;
        O_CPU_WAITn = ~(w_wr_stall | w_rd_stall);
        if (w_wr_stb) begin
            O_VRAM_AB = w_buf_addr;
            O_VRAM_DB = w_buf_data;
        end else if (w_rd_stb) begin
            O_VRAM_AB = r_rd_addr;
        end
        if (w_rd_hold) begin
            O_CPU_DB = r_rd_data;
        end
    end

endmodule
